// File: rtl/fir_pkg.sv
// Shared FIR output-path constants and saturation-limit helpers.
package fir_pkg;
  localparam int FIR_IN_W  = 34;
  localparam int FIR_OUT_W = 16;
  localparam int FIR_SHIFT = 15;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int FIR_SAT_MAX = sat_max(FIR_OUT_W);
  localparam int FIR_SAT_MIN = sat_min(FIR_OUT_W);
endpackage

// File: rtl/fir_out_sink_if.sv
// Input (FIR result) and output (audio) stream signals of fir_out_sink.
interface fir_out_sink_if
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_IN_W,
  parameter int OUT_W = FIR_OUT_W
);
  logic             s_axis_data_tvalid;
  logic [IN_W-1:0]  s_axis_data_tdata;
  logic             s_axis_data_tready;
  logic             m_axis_data_tvalid;
  logic             m_axis_data_tready;
  logic [OUT_W-1:0] m_axis_data_tdata;

  modport slave (
    input  s_axis_data_tvalid, s_axis_data_tdata, m_axis_data_tready,
    output s_axis_data_tready, m_axis_data_tvalid, m_axis_data_tdata
  );

  modport master (
    output s_axis_data_tvalid, s_axis_data_tdata, m_axis_data_tready,
    input  s_axis_data_tready, m_axis_data_tvalid, m_axis_data_tdata
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; a push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge aclk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fir_out_sink.sv
// FIR result sink: round-half-up, saturate to OUT_W, buffer and re-emit with backpressure.
module fir_out_sink
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_IN_W,
  parameter int OUT_W = FIR_OUT_W,
  parameter int SHIFT = FIR_SHIFT,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             areset,
  fir_out_sink_if.slave    bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sat_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int RW     = IN_W + 1 - SHIFT;
  localparam int STAGES = 2;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam logic signed [IN_W:0]  RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [RW-1:0]  HI  = RW'(sat_max(OUT_W));
  localparam logic signed [RW-1:0]  LO  = RW'(sat_min(OUT_W));

  logic [STAGES:1]      vld_pipe;
  logic signed [IN_W:0] sum;
  logic signed [RW-1:0] r_q;
  logic [OUT_W-1:0]     sat_d, sat_q;
  logic                 clamp, sat_inc, push, pop, full, empty, drop;
  logic [CW-1:0]        count;

  // One extra bit of headroom so adding the rounding constant cannot overflow.
  assign sum = $signed({bus.s_axis_data_tdata[IN_W-1], bus.s_axis_data_tdata}) + RND;

  always_comb begin
    clamp = 1'b0;
    sat_d = r_q[OUT_W-1:0];
    if (r_q > HI) begin
      clamp = 1'b1;
      sat_d = HI[OUT_W-1:0];
    end else if (r_q < LO) begin
      clamp = 1'b1;
      sat_d = LO[OUT_W-1:0];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_pipe <= '0;
      r_q      <= '0;
      sat_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.s_axis_data_tvalid};
      r_q      <= RW'(sum >>> SHIFT);
      sat_q    <= sat_d;
    end
  end

  assign sat_inc = vld_pipe[1] && clamp;
  assign push    = vld_pipe[STAGES];
  assign pop     = bus.m_axis_data_tvalid && bus.m_axis_data_tready;
  assign drop    = push && full && !pop;

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge aclk) begin
    if (areset || clr_cnt) begin
      sat_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (sat_inc && !(&sat_cnt))  sat_cnt  <= sat_cnt + 1'b1;
      if (drop && !(&drop_cnt))    drop_cnt <= drop_cnt + 1'b1;
    end
  end

  sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (push),
    .pop    (pop),
    .din    (sat_q),
    .dout   (bus.m_axis_data_tdata),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign bus.m_axis_data_tvalid = !empty;
  assign bus.s_axis_data_tready = (count != CW'(DEPTH));
endmodule

// File: tb/tb_fir_out_sink.sv
// Directed bench for fir_out_sink: rounding, saturation, backpressure, reset, counters.
module tb_fir_out_sink;
  import fir_pkg::*;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic clr_cnt = 1'b0, clr_cnt2 = 1'b0;
  logic [15:0] sat_cnt, drop_cnt;
  logic [1:0]  sat_cnt2, drop_cnt2;
  int n_chk = 0, n_fail = 0;

  always #5 aclk = ~aclk;

  fir_out_sink_if bus ();
  fir_out_sink_if bus2 ();

  fir_out_sink u_dut (
    .aclk(aclk), .areset(areset), .bus(bus),
    .clr_cnt(clr_cnt), .sat_cnt(sat_cnt), .drop_cnt(drop_cnt)
  );

  fir_out_sink #(.CNT_W(2)) u_cnt (
    .aclk(aclk), .areset(areset), .bus(bus2),
    .clr_cnt(clr_cnt2), .sat_cnt(sat_cnt2), .drop_cnt(drop_cnt2)
  );

  localparam logic [33:0] BIG_P = 34'd2147483648;
  localparam logic [33:0] BIG_N = -34'sd2147483648;
  logic [33:0] rin [5] = '{34'd32768, 34'd16384, 34'd16383, -34'sd16384, -34'sd16385};
  logic [15:0] rexp[5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
  logic [15:0] sat_hi, sat_lo;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Single sample into an empty FIFO with tready=1: check 2-edge latency.
  task automatic send_one(input logic [33:0] d, input logic [15:0] exp, input string tag);
    bus.s_axis_data_tvalid = 1'b1;
    bus.s_axis_data_tdata  = d;
    tick;
    bus.s_axis_data_tvalid = 1'b0;
    tick;
    chk({tag, "_early"}, bus.m_axis_data_tvalid, 0);
    tick;
    chk({tag, "_vld"}, bus.m_axis_data_tvalid, 1);
    chk({tag, "_dat"}, bus.m_axis_data_tdata, exp);
    tick;
  endtask

  initial begin
    sat_hi = 16'(FIR_SAT_MAX);
    sat_lo = 16'(FIR_SAT_MIN);
    bus.s_axis_data_tvalid  = 1'b0;
    bus.s_axis_data_tdata   = '0;
    bus.m_axis_data_tready  = 1'b0;
    bus2.s_axis_data_tvalid = 1'b0;
    bus2.s_axis_data_tdata  = '0;
    bus2.m_axis_data_tready = 1'b0;
    tick; tick;
    areset = 1'b0;

    chk("rst_mvld",  bus.m_axis_data_tvalid, 0);
    chk("rst_mdat",  bus.m_axis_data_tdata, 0);
    chk("rst_srdy",  bus.s_axis_data_tready, 1);
    chk("rst_sat",   sat_cnt, 0);
    chk("rst_drop",  drop_cnt, 0);
    chk("rst2_mvld", bus2.m_axis_data_tvalid, 0);

    // Rounding, back-to-back, tready=1
    bus.m_axis_data_tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.s_axis_data_tvalid = (i < 5);
      bus.s_axis_data_tdata  = (i < 5) ? rin[i] : '0;
      tick;
      if (i >= 2) begin
        chk($sformatf("rnd%0d_vld", i - 2), bus.m_axis_data_tvalid, 1);
        chk($sformatf("rnd%0d_dat", i - 2), bus.m_axis_data_tdata, rexp[i - 2]);
      end
    end
    bus.s_axis_data_tvalid = 1'b0;
    tick;
    chk("rnd_empty", bus.m_axis_data_tvalid, 0);
    chk("rnd_sat",   sat_cnt, 0);

    // Saturation
    send_one(BIG_P, sat_hi, "satp");
    send_one(BIG_N, sat_lo, "satn");
    chk("sat_cnt2", sat_cnt, 2);
    send_one(34'd1073709056, 16'h7FFF, "exact");
    chk("exact_cnt", sat_cnt, 2);

    // Backpressure and drop
    bus.m_axis_data_tready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      bus.s_axis_data_tvalid = 1'b1;
      bus.s_axis_data_tdata  = 34'(i * 32768);
      tick;
    end
    bus.s_axis_data_tvalid = 1'b0;
    tick; tick;
    chk("bp_srdy", bus.s_axis_data_tready, 0);
    chk("bp_drop", drop_cnt, 2);
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_vld", bus.m_axis_data_tvalid, 1);
      chk("bp_hold_dat", bus.m_axis_data_tdata, 1);
      tick;
    end
    bus.m_axis_data_tready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      tick;
      chk($sformatf("bp_out%0d", k), bus.m_axis_data_tdata, 16'(k));
    end
    tick;
    chk("bp_empty", bus.m_axis_data_tvalid, 0);
    chk("bp_srdy1", bus.s_axis_data_tready, 1);

    // Simultaneous push and pop at full
    bus.m_axis_data_tready = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      bus.s_axis_data_tvalid = 1'b1;
      bus.s_axis_data_tdata  = 34'(i * 32768);
      tick;
    end
    bus.s_axis_data_tvalid = 1'b0;
    tick; tick;
    chk("pp_full", bus.s_axis_data_tready, 0);
    bus.s_axis_data_tvalid = 1'b1;
    bus.s_axis_data_tdata  = 34'(14 * 32768);
    tick;
    bus.s_axis_data_tvalid = 1'b0;
    tick;
    bus.m_axis_data_tready = 1'b1;
    tick;
    bus.m_axis_data_tready = 1'b0;
    chk("pp_drop", drop_cnt, 2);
    chk("pp_still_full", bus.s_axis_data_tready, 0);
    chk("pp_head", bus.m_axis_data_tdata, 11);
    bus.m_axis_data_tready = 1'b1;
    for (int k = 12; k <= 14; k++) begin
      tick;
      chk($sformatf("pp_out%0d", k), bus.m_axis_data_tdata, 16'(k));
    end
    tick;
    chk("pp_empty", bus.m_axis_data_tvalid, 0);

    // Reset mid-stream: 3 buffered, 2 in flight
    bus.m_axis_data_tready = 1'b0;
    for (int i = 20; i <= 22; i++) begin
      bus.s_axis_data_tvalid = 1'b1;
      bus.s_axis_data_tdata  = 34'(i * 32768);
      tick;
    end
    bus.s_axis_data_tvalid = 1'b0;
    tick; tick;
    for (int i = 23; i <= 24; i++) begin
      bus.s_axis_data_tvalid = 1'b1;
      bus.s_axis_data_tdata  = 34'(i * 32768);
      tick;
    end
    bus.s_axis_data_tvalid = 1'b0;
    areset = 1'b1;
    tick;
    areset = 1'b0;
    chk("mr_mvld", bus.m_axis_data_tvalid, 0);
    chk("mr_mdat", bus.m_axis_data_tdata, 0);
    chk("mr_sat",  sat_cnt, 0);
    chk("mr_drop", drop_cnt, 0);
    chk("mr_srdy", bus.s_axis_data_tready, 1);
    tick; tick;
    chk("mr_ghost", bus.m_axis_data_tvalid, 0);
    bus.m_axis_data_tready = 1'b1;
    send_one(34'(25 * 32768), 16'd25, "mr_new");

    // Counter saturation and clear on the CNT_W=2 instance
    for (int i = 0; i < 9; i++) begin
      bus2.s_axis_data_tvalid = 1'b1;
      bus2.s_axis_data_tdata  = (i < 4) ? 34'((i + 1) * 32768) : BIG_P;
      tick;
    end
    bus2.s_axis_data_tvalid = 1'b0;
    tick; tick;
    chk("cnt_drop_hold", drop_cnt2, 3);
    chk("cnt_sat_hold",  sat_cnt2, 3);
    chk("cnt_srdy",      bus2.s_axis_data_tready, 0);
    chk("cnt_head",      bus2.m_axis_data_tdata, 1);
    bus2.s_axis_data_tvalid = 1'b1;
    bus2.s_axis_data_tdata  = BIG_P;
    tick;
    bus2.s_axis_data_tvalid = 1'b0;
    tick;
    clr_cnt2 = 1'b1;
    tick;
    clr_cnt2 = 1'b0;
    chk("clr_drop", drop_cnt2, 0);
    chk("clr_sat",  sat_cnt2, 0);
    tick;
    chk("clr_drop_after", drop_cnt2, 0);
    chk("clr_head",       bus2.m_axis_data_tdata, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
